// File: rtl/fb_pkg.sv
// Shared types and default geometry for the frame-buffer access controller.
package fb_pkg;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 3;
  localparam int unsigned X_W       = 11;
  localparam int unsigned Y_W       = 10;
  localparam int unsigned RES_H     = 1280;
  localparam int unsigned RES_V     = 960;
  localparam int unsigned CLR_DEPTH = 800;
  localparam int unsigned FIFO_D    = 4;
  localparam int unsigned HOLD      = 5;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [DATA_W-1:0] rgb;
  } pixel_wr_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Pixel-write queue: synchronous FIFO with flush, registered full/empty flags
// and a peek at the entry behind the head so writes can run back to back.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  pixel_wr_t din,
  input  logic      pop,
  output pixel_wr_t head,
  output pixel_wr_t next_head,
  output logic      many,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pixel_wr_t        mem [DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]   wr_ptr_nx, rd_ptr_nx;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] rd_idx_nx;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    if (flush) begin
      wr_ptr_nx = '0;
      rd_ptr_nx = '0;
    end else begin
      if (do_push) wr_ptr_nx = wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr_nx = rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
      full   <= (wr_ptr_nx - rd_ptr_nx) == (PTR_W+1)'(DEPTH);
      empty  <= wr_ptr_nx == rd_ptr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  assign count     = wr_ptr - rd_ptr;
  assign many      = count > (PTR_W+1)'(1);
  assign rd_idx_nx = rd_ptr[PTR_W-1:0] + PTR_W'(1);
  assign head      = mem[rd_ptr[PTR_W-1:0]];
  assign next_head = mem[rd_idx_nx];

endmodule

// File: rtl/fb_access_ctrl.sv
// Sequencer/arbiter in front of the RGB frame memory: clear sweeps, display
// read pass-through, and queued pixel writes issued only during blanking.
module fb_access_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_W,
  parameter int unsigned DATA_WIDTH   = DATA_W,
  parameter int unsigned X_WIRE_WIDTH = X_W,
  parameter int unsigned Y_WIRE_WIDTH = Y_W,
  parameter int unsigned RESOLUTION_H = RES_H,
  parameter int unsigned RESOLUTION_V = RES_V,
  parameter int unsigned CLEAR_DEPTH  = CLR_DEPTH,
  parameter int unsigned FIFO_DEPTH   = FIFO_D,
  parameter int unsigned WR_HOLD      = HOLD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_req,
  input  logic                    display_on_in,
  input  logic [X_WIRE_WIDTH-1:0] disp_hpos,
  input  logic [Y_WIRE_WIDTH-1:0] disp_vpos,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [X_WIRE_WIDTH-1:0] wr_x,
  input  logic [Y_WIRE_WIDTH-1:0] wr_y,
  input  logic [DATA_WIDTH-1:0]   wr_rgb,
  output logic                    clear_busy,
  output logic                    oob_err,
  output logic                    mem_display_on,
  output logic                    mem_memreset,
  output logic [ADDR_WIDTH-1:0]   mem_resetcnt,
  output logic [X_WIRE_WIDTH-1:0] mem_hpos,
  output logic [Y_WIRE_WIDTH-1:0] mem_vpos,
  output logic [DATA_WIDTH-1:0]   mem_rgbin
);

  localparam int unsigned HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = ADDR_WIDTH'(CLEAR_DEPTH - 1);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(WR_HOLD - 1);

  state_t                  state, state_nx;
  logic [HOLD_W-1:0]       hold_cnt, hold_nx;
  logic                    disp_nx, memreset_nx, busy_nx, oob_nx;
  logic [ADDR_WIDTH-1:0]   cnt_nx;
  logic [X_WIRE_WIDTH-1:0] hpos_nx;
  logic [Y_WIRE_WIDTH-1:0] vpos_nx;
  logic [DATA_WIDTH-1:0]   rgb_nx;

  pixel_wr_t wr_pix, head, next_head;
  logic      fifo_full, fifo_empty, fifo_many;
  logic      accept, in_range, push, pop, flush;

  assign wr_ready = !fifo_full && !clear_busy;
  assign accept   = wr_valid && wr_ready;
  assign in_range = (wr_x < X_WIRE_WIDTH'(RESOLUTION_H)) && (wr_y < Y_WIRE_WIDTH'(RESOLUTION_V));
  assign push     = accept && in_range;
  assign oob_nx   = oob_err || (accept && !in_range);
  assign wr_pix   = '{x: wr_x, y: wr_y, rgb: wr_rgb};

  fb_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .flush    (flush),
    .push     (push),
    .din      (wr_pix),
    .pop      (pop),
    .head     (head),
    .next_head(next_head),
    .many     (fifo_many),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    hold_nx     = hold_cnt;
    disp_nx     = mem_display_on;
    memreset_nx = mem_memreset;
    busy_nx     = clear_busy;
    cnt_nx      = mem_resetcnt;
    hpos_nx     = mem_hpos;
    vpos_nx     = mem_vpos;
    rgb_nx      = mem_rgbin;
    pop         = 1'b0;
    flush       = 1'b0;

    if (clear_req) begin
      state_nx    = CLEAR;
      flush       = 1'b1;
      hold_nx     = '0;
      disp_nx     = 1'b1;
      memreset_nx = 1'b0;
      busy_nx     = 1'b1;
      cnt_nx      = '0;
      hpos_nx     = '0;
      vpos_nx     = '0;
      rgb_nx      = '0;
    end else begin
      unique case (state)
        CLEAR: begin
          disp_nx = 1'b1;
          if (mem_resetcnt == CLR_LAST) begin
            memreset_nx = 1'b1;
            busy_nx     = 1'b0;
            state_nx    = RUN;
          end else begin
            cnt_nx = mem_resetcnt + ADDR_WIDTH'(1);
          end
        end
        RUN: begin
          disp_nx = display_on_in;
          hpos_nx = disp_hpos;
          vpos_nx = disp_vpos;
          if (!display_on_in && !fifo_empty) begin
            state_nx = WRITE;
            disp_nx  = 1'b0;
            hpos_nx  = head.x;
            vpos_nx  = head.y;
            rgb_nx   = head.rgb;
            hold_nx  = '0;
          end
        end
        WRITE: begin
          // Active video pre-empts the write; the head entry stays queued
          // and restarts its full hold in the next blanking interval.
          if (display_on_in) begin
            state_nx = RUN;
            disp_nx  = 1'b1;
            hpos_nx  = disp_hpos;
            vpos_nx  = disp_vpos;
            hold_nx  = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            pop     = 1'b1;
            hold_nx = '0;
            if (fifo_many) begin
              disp_nx = 1'b0;
              hpos_nx = next_head.x;
              vpos_nx = next_head.y;
              rgb_nx  = next_head.rgb;
            end else begin
              state_nx = RUN;
              disp_nx  = display_on_in;
              hpos_nx  = disp_hpos;
              vpos_nx  = disp_vpos;
            end
          end else begin
            hold_nx = hold_cnt + HOLD_W'(1);
          end
        end
        default: state_nx = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt       <= '0;
      mem_display_on <= 1'b1;
      mem_memreset   <= 1'b0;
      clear_busy     <= 1'b1;
      oob_err        <= 1'b0;
      mem_resetcnt   <= '0;
      mem_hpos       <= '0;
      mem_vpos       <= '0;
      mem_rgbin      <= '0;
    end else begin
      hold_cnt       <= hold_nx;
      mem_display_on <= disp_nx;
      mem_memreset   <= memreset_nx;
      clear_busy     <= busy_nx;
      oob_err        <= oob_nx;
      mem_resetcnt   <= cnt_nx;
      mem_hpos       <= hpos_nx;
      mem_vpos       <= vpos_nx;
      mem_rgbin      <= rgb_nx;
    end
  end

endmodule
